dq_lane_dly_seq: RTL and testbench

Delay-programming sequencer for one DDR3 byte lane of single-bit DQ/DM I/O cells, running in the `clk_div` domain. It holds a shadow bank of per-bit input and output delay values and tracks which ones are dirty. On an `apply` request it walks every entry in a fixed order, issuing `set_idelay`/`set_odelay` strobes with `dly_data` for the dirty ones. After a programmable gap it fires one lane-wide `ld_*` pulse, so all new delays take effect on the same `clk_div` cycle. It replaces per-bit ad-hoc delay writes from the PHY control logic.

---
 rtl/dq_lane_dly_seq.sv | 186 ++++++++++++++++++
 tb/tb_dq_lane_dly_seq.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dq_lane_dly_seq.sv
// Delay-programming sequencer for one DDR3 byte lane: shadows per-bit idelay/odelay
// values, walks dirty entries on apply and fires one lane-wide load pulse.
module dq_lane_dly_seq #(
  parameter int unsigned          NUM_DQ     = 9,
  parameter int unsigned          ADDR_WIDTH = 5,
  parameter int unsigned          DLY_WIDTH  = 8,
  parameter int unsigned          LD_GAP     = 2,
  parameter logic [DLY_WIDTH-1:0] DLY_INIT   = '0
) (
  input  logic                  clk_div,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DLY_WIDTH-1:0]  wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  apply,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DLY_WIDTH-1:0]  rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [DLY_WIDTH-1:0]  dly_data,
  output logic [NUM_DQ-1:0]     set_idelay,
  output logic [NUM_DQ-1:0]     set_odelay,
  output logic [NUM_DQ-1:0]     ld_idelay,
  output logic [NUM_DQ-1:0]     ld_odelay
);

  localparam int unsigned NUM_ENT = 2 * NUM_DQ;
  localparam int unsigned ENT_W   = $clog2(NUM_ENT);
  localparam int unsigned BIT_W   = ADDR_WIDTH - 1;

  typedef enum logic [2:0] {IDLE, WALK, GAP, LOAD, DONE} state_t;

  state_t                 state, state_nx;
  logic [ENT_W-1:0]       idx, idx_nx;
  logic [3:0]             gap_cnt, gap_nx;
  logic                   pending, pending_nx;
  logic [NUM_DQ-1:0]      mask_i, mask_i_nx, mask_o, mask_o_nx;
  logic                   busy_nx, done_nx;
  logic [DLY_WIDTH-1:0]   dly_nx;
  logic [NUM_DQ-1:0]      set_i_nx, set_o_nx, ld_i_nx, ld_o_nx;
  logic [DLY_WIDTH-1:0]   shadow [NUM_ENT];
  logic [NUM_ENT-1:0]     dirty, clr_dirty;
  logic                   is_out;
  logic [NUM_DQ-1:0]      bit_oh;
  logic                   wr_ok, rd_ok, wr_hit;
  logic [ENT_W-1:0]       wr_ent, rd_ent;

  // Entry index is {sel_out, bit} flattened to sel_out*NUM_DQ + bit (the walk order).
  function automatic logic [ENT_W-1:0] ent_of(input logic [ADDR_WIDTH-1:0] a);
    ent_of = a[ADDR_WIDTH-1] ? ENT_W'(NUM_DQ + 32'(a[BIT_W-1:0])) : ENT_W'(a[BIT_W-1:0]);
  endfunction

  assign wr_ok    = 32'(wr_addr[BIT_W-1:0]) < NUM_DQ;
  assign rd_ok    = 32'(rd_addr[BIT_W-1:0]) < NUM_DQ;
  assign wr_ent   = ent_of(wr_addr);
  assign rd_ent   = ent_of(rd_addr);
  assign wr_ready = ~busy;
  assign wr_hit   = wr_valid & wr_ready & wr_ok;

  // A write landing on the entry being walked keeps it dirty for the next apply.
  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      for (int unsigned e = 0; e < NUM_ENT; e++) shadow[e] <= DLY_INIT;
      dirty   <= '1;
      rd_data <= '0;
    end else begin
      for (int unsigned e = 0; e < NUM_ENT; e++) begin
        if (wr_hit && wr_ent == ENT_W'(e)) begin
          shadow[e] <= wr_data;
          dirty[e]  <= 1'b1;
        end else if (clr_dirty[e]) begin
          dirty[e] <= 1'b0;
        end
      end
      rd_data <= rd_ok ? shadow[rd_ent] : '0;
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      pending    <= 1'b0;
      mask_i     <= '0;
      mask_o     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dly_data   <= '0;
      set_idelay <= '0;
      set_odelay <= '0;
      ld_idelay  <= '0;
      ld_odelay  <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      gap_cnt    <= gap_nx;
      pending    <= pending_nx;
      mask_i     <= mask_i_nx;
      mask_o     <= mask_o_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      dly_data   <= dly_nx;
      set_idelay <= set_i_nx;
      set_odelay <= set_o_nx;
      ld_idelay  <= ld_i_nx;
      ld_odelay  <= ld_o_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    gap_nx     = gap_cnt;
    pending_nx = pending | (apply & (state != IDLE));
    mask_i_nx  = mask_i;
    mask_o_nx  = mask_o;
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    dly_nx     = '0;
    set_i_nx   = '0;
    set_o_nx   = '0;
    ld_i_nx    = '0;
    ld_o_nx    = '0;
    clr_dirty  = '0;
    is_out     = 32'(idx) >= NUM_DQ;
    bit_oh     = NUM_DQ'(1) << (is_out ? 32'(idx) - NUM_DQ : 32'(idx));
    unique case (state)
      IDLE: begin
        if (apply) begin
          state_nx  = WALK;
          idx_nx    = '0;
          mask_i_nx = '0;
          mask_o_nx = '0;
          busy_nx   = 1'b1;
        end
      end
      WALK: begin
        busy_nx = 1'b1;
        if (dirty[idx]) begin
          dly_nx         = shadow[idx];
          clr_dirty[idx] = 1'b1;
          if (is_out) begin
            set_o_nx  = bit_oh;
            mask_o_nx = mask_o | bit_oh;
          end else begin
            set_i_nx  = bit_oh;
            mask_i_nx = mask_i | bit_oh;
          end
        end
        if (idx == ENT_W'(NUM_ENT - 1)) begin
          gap_nx   = '0;
          state_nx = (LD_GAP == 0) ? LOAD : GAP;
        end else begin
          idx_nx = idx + ENT_W'(1);
        end
      end
      GAP: begin
        busy_nx = 1'b1;
        gap_nx  = gap_cnt + 4'd1;
        if (32'(gap_cnt) + 1 >= LD_GAP) state_nx = LOAD;
      end
      LOAD: begin
        busy_nx  = 1'b1;
        ld_i_nx  = mask_i;
        ld_o_nx  = mask_o;
        state_nx = DONE;
      end
      DONE: begin
        done_nx = 1'b1;
        if (pending | apply) begin
          state_nx   = WALK;
          idx_nx     = '0;
          mask_i_nx  = '0;
          mask_o_nx  = '0;
          pending_nx = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dq_lane_dly_seq.sv
// Scoreboard bench for dq_lane_dly_seq: expected per-cycle outputs are queued when
// apply is driven and compared every falling edge.
module tb_dq_lane_dly_seq;
  localparam int unsigned N  = 9;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned G  = 2;
  localparam int unsigned NE = 2 * N;
  localparam int unsigned WL = 2 * N + G + 3;

  logic          clk_div;
  logic          rst;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data, dly_data;
  logic          wr_valid, wr_ready, apply, busy, done;
  logic [N-1:0]  set_idelay, set_odelay, ld_idelay, ld_odelay;

  dq_lane_dly_seq #(
    .NUM_DQ(N), .ADDR_WIDTH(AW), .DLY_WIDTH(DW), .LD_GAP(G), .DLY_INIT(8'h00)
  ) dut (
    .clk_div(clk_div), .rst(rst), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .apply(apply), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .dly_data(dly_data),
    .set_idelay(set_idelay), .set_odelay(set_odelay),
    .ld_idelay(ld_idelay), .ld_odelay(ld_odelay)
  );

  typedef struct packed {
    logic          wr_ready;
    logic          busy;
    logic          done;
    logic [DW-1:0] dly;
    logic [N-1:0]  set_i;
    logic [N-1:0]  set_o;
    logic [N-1:0]  ld_i;
    logic [N-1:0]  ld_o;
  } obs_t;

  obs_t          exp_q[$];
  logic [DW-1:0] sh_m [NE];
  logic          dirty_m [NE];
  int            tests = 0;
  int            fails = 0;

  initial clk_div = 1'b0;
  always #5 clk_div = ~clk_div;

  function automatic obs_t idle_obs();
    obs_t o;
    o          = '0;
    o.wr_ready = 1'b1;
    return o;
  endfunction

  function automatic int ent_of(input logic [AW-1:0] a);
    return a[AW-1] ? N + int'(a[AW-2:0]) : int'(a[AW-2:0]);
  endfunction

  function automatic logic [AW-1:0] addr_of(input int e);
    logic [AW-1:0] a;
    a = (e < N) ? AW'(e) : AW'(16 + e - N);
    return a;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < NE; e++) begin
      sh_m[e]    = 8'h00;
      dirty_m[e] = 1'b1;
    end
  endtask

  // Expected outputs for cycles after edges 0..WL-1 of a walk; a chained walk's
  // edge 0 coincides with the previous done cycle, so that record is skipped.
  task automatic push_walk(input bit chained);
    obs_t         r [WL];
    logic [N-1:0] mi, mo;
    mi = '0;
    mo = '0;
    for (int k = 0; k < WL; k++) begin
      r[k]          = '0;
      r[k].busy     = (k < WL - 1);
      r[k].wr_ready = !r[k].busy;
      r[k].done     = (k == WL - 1);
    end
    for (int e = 0; e < NE; e++) begin
      if (dirty_m[e]) begin
        r[e+1].dly = sh_m[e];
        if (e < N) begin
          r[e+1].set_i[e] = 1'b1;
          mi[e]           = 1'b1;
        end else begin
          r[e+1].set_o[e-N] = 1'b1;
          mo[e-N]           = 1'b1;
        end
        dirty_m[e] = 1'b0;
      end
    end
    r[WL-2].ld_i = mi;
    r[WL-2].ld_o = mo;
    for (int k = chained ? 1 : 0; k < WL; k++) exp_q.push_back(r[k]);
  endtask

  always @(negedge clk_div) begin : monitor
    obs_t e, g;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_obs();
    g = {wr_ready, busy, done, dly_data, set_idelay, set_odelay, ld_idelay, ld_odelay};
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL cycle_outputs @%0t: got rdy=%b busy=%b done=%b dly=%h si=%h so=%h li=%h lo=%h, expected rdy=%b busy=%b done=%b dly=%h si=%h so=%h li=%h lo=%h",
               $time, g.wr_ready, g.busy, g.done, g.dly, g.set_i, g.set_o, g.ld_i, g.ld_o,
               e.wr_ready, e.busy, e.done, e.dly, e.set_i, e.set_o, e.ld_i, e.ld_o);
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit with_apply);
    int e;
    @(negedge clk_div);
    #1;
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    apply    = with_apply;
    tests++;
    if (wr_ready !== 1'b1) begin
      fails++;
      $display("FAIL wr_ready_idle: got %b, expected 1", wr_ready);
    end
    if (a[AW-2:0] < N) begin
      e          = ent_of(a);
      sh_m[e]    = d;
      dirty_m[e] = 1'b1;
    end
    if (with_apply) push_walk(1'b0);
    @(negedge clk_div);
    #1;
    wr_valid = 1'b0;
    apply    = 1'b0;
  endtask

  task automatic apply_walk();
    @(negedge clk_div);
    #1;
    apply = 1'b1;
    push_walk(1'b0);
    @(negedge clk_div);
    #1;
    apply = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    @(negedge clk_div);
    #1;
    rd_addr = a;
    @(negedge clk_div);
    d = rd_data;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk_div);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    repeat (3) @(negedge clk_div);
    tests++;
    if ({busy, done, wr_ready} !== 3'b001) begin
      fails++;
      $display("FAIL reset_flags: got busy,done,rdy=%b, expected 001", {busy, done, wr_ready});
    end
    tests++;
    if ({set_idelay, set_odelay, ld_idelay, ld_odelay, dly_data} !== '0) begin
      fails++;
      $display("FAIL reset_strobes: got si=%h so=%h li=%h lo=%h dly=%h, expected 0",
               set_idelay, set_odelay, ld_idelay, ld_odelay, dly_data);
    end
    #1;
    rst = 1'b0;
    rd(5'h05, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL reset_shadow_i5: got %h, expected 00", d);
    end
    rd(5'h18, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL reset_shadow_o8: got %h, expected 00", d);
    end
  endtask

  task automatic test_full_walk();
    apply_walk();
    drain();
  endtask

  task automatic test_sparse();
    logic [DW-1:0] d;
    wr(5'h03, 8'h2A, 1'b0);
    wr(5'h18, 8'h51, 1'b1);
    drain();
    rd(5'h03, d);
    tests++;
    if (d !== 8'h2A) begin
      fails++;
      $display("FAIL sparse_rd_i3: got %h, expected 2a", d);
    end
    rd(5'h18, d);
    tests++;
    if (d !== 8'h51) begin
      fails++;
      $display("FAIL sparse_rd_o8: got %h, expected 51", d);
    end
  endtask

  task automatic test_clean();
    apply_walk();
    drain();
  endtask

  task automatic test_back_to_back();
    int            n;
    logic [DW-1:0] d;
    wr(5'h01, 8'h11, 1'b0);
    apply_walk();
    repeat (3) @(negedge clk_div);
    #1;
    apply = 1'b1;
    push_walk(1'b1);
    @(negedge clk_div);
    #1;
    apply = 1'b0;
    repeat (2) @(negedge clk_div);
    #1;
    apply = 1'b1;
    @(negedge clk_div);
    #1;
    apply    = 1'b0;
    wr_addr  = 5'h00;
    wr_data  = 8'h77;
    wr_valid = 1'b1;
    rd_addr  = 5'h00;
    @(negedge clk_div);
    tests++;
    if (wr_ready !== 1'b0) begin
      fails++;
      $display("FAIL stall_wr_ready: got %b, expected 0", wr_ready);
    end
    @(negedge clk_div);
    tests++;
    if (rd_data !== sh_m[0]) begin
      fails++;
      $display("FAIL stall_no_land: got %h, expected %h", rd_data, sh_m[0]);
    end
    n = 0;
    do begin
      @(posedge clk_div);
      #1;
      n++;
    end while (!wr_ready && n < 60);
    tests++;
    if (wr_ready !== 1'b1 || done !== 1'b1) begin
      fails++;
      $display("FAIL stall_release: got rdy=%b done=%b, expected rdy=1 done=1", wr_ready, done);
    end
    @(posedge clk_div);
    #1;
    wr_valid   = 1'b0;
    sh_m[0]    = 8'h77;
    dirty_m[0] = 1'b1;
    drain();
    rd(5'h00, d);
    tests++;
    if (d !== 8'h77) begin
      fails++;
      $display("FAIL stall_landed: got %h, expected 77", d);
    end
    apply_walk();
    drain();
  endtask

  task automatic test_bad_index();
    logic [DW-1:0] d;
    wr(5'h0C, 8'h99, 1'b0);
    wr(5'h1D, 8'h66, 1'b0);
    for (int e = 0; e < NE; e++) begin
      rd(addr_of(e), d);
      tests++;
      if (d !== sh_m[e]) begin
        fails++;
        $display("FAIL bad_idx_rd[%0d]: got %h, expected %h", e, d, sh_m[e]);
      end
    end
    apply_walk();
    drain();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    wr(5'h08, 8'h3C, 1'b0);
    wr(5'h07, 8'h05, 1'b0);
    wr(5'h10, 8'h44, 1'b1);
    repeat (10) @(posedge clk_div);
    #1;
    tests++;
    if (set_odelay !== 9'h001 || dly_data !== 8'h44) begin
      fails++;
      $display("FAIL pre_rst_strobe: got so=%h dly=%h, expected so=001 dly=44", set_odelay, dly_data);
    end
    rst = 1'b1;
    exp_q.delete();
    #1;
    tests++;
    if ({set_idelay, set_odelay, ld_idelay, ld_odelay, dly_data, busy, done} !== '0) begin
      fails++;
      $display("FAIL rst_mid_walk: got si=%h so=%h li=%h lo=%h dly=%h busy=%b done=%b, expected 0",
               set_idelay, set_odelay, ld_idelay, ld_odelay, dly_data, busy, done);
    end
    repeat (2) @(negedge clk_div);
    #1;
    rst = 1'b0;
    model_reset();
    rd(5'h08, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_rd_i8: got %h, expected 00", d);
    end
    rd(5'h10, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_rd_o0: got %h, expected 00", d);
    end
    apply_walk();
    drain();
  endtask

  initial begin
    rst      = 1'b1;
    wr_addr  = '0;
    wr_data  = '0;
    wr_valid = 1'b0;
    apply    = 1'b0;
    rd_addr  = '0;
    model_reset();
    test_reset();
    test_full_walk();
    test_sparse();
    test_clean();
    test_back_to_back();
    test_bad_index();
    test_reset_mid();
    repeat (3) @(negedge clk_div);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", fails);
    $fatal(1);
  end

endmodule
